// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared widths and types for the scanned seven-segment display path
package seven_seg_pkg;
  localparam int MAX_DIGITS = 8;
  localparam int SEL_W = 3;
  localparam int NIBBLE_W = 4;
  typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: free-running 0..DIV-1 counter producing a one-cycle tick at the wrap
module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  // wrap to zero on the terminal count, otherwise count up
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes a hex value across digits, swapping in new values only at frame boundaries
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           upd_valid,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] upd_value,
  input  logic [NUM_DIGITS-1:0]          upd_digit_en,
  output logic                           upd_ready,
  output logic [SEL_W-1:0]               select,
  output logic [NIBBLE_W-1:0]            nibble,
  output logic                           blank,
  output logic                           frame_tick
);
  localparam int VW = NIBBLE_W * NUM_DIGITS;
  localparam int XW = NIBBLE_W * MAX_DIGITS;
  logic                  tick, boundary, accept, apply;
  logic [SEL_W-1:0]      digit_q, digit_d;
  logic [VW-1:0]         act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic                  pend_full_q, pend_full_d, frame_tick_q;
  logic [XW-1:0]         val_ext;
  logic [MAX_DIGITS-1:0] en_ext;
  nibble_t               cur_nibble;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign boundary = tick && digit_q == SEL_W'(NUM_DIGITS - 1);
  assign accept   = upd_valid && !pend_full_q;
  assign apply    = boundary && pend_full_q;

  // advance the digit on each tick, wrapping at the last digit of the frame
  always_comb digit_d = !tick ? digit_q : boundary ? '0 : digit_q + 1'b1;

  // pending buffer fills on accept and drains into active at a frame boundary;
  // accept needs an empty buffer, so it never races an apply
  always_comb begin
    act_val_d   = apply ? pend_val_q : act_val_q;
    act_en_d    = apply ? pend_en_q : act_en_q;
    pend_val_d  = accept ? upd_value : pend_val_q;
    pend_en_d   = accept ? upd_digit_en : pend_en_q;
    pend_full_d = accept | (pend_full_q & ~boundary);
  end

  // all scanner state, cleared asynchronously so a reset blanks the display at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      digit_q      <= '0;
      act_val_q    <= '0;
      act_en_q     <= '0;
      pend_val_q   <= '0;
      pend_en_q    <= '0;
      pend_full_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      act_val_q    <= act_val_d;
      act_en_q     <= act_en_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pend_full_q  <= pend_full_d;
      frame_tick_q <= boundary;
    end

  // outputs decode registered state only; zero-extension keeps indexing legal for short displays
  always_comb begin
    val_ext    = XW'(act_val_q);
    en_ext     = MAX_DIGITS'(act_en_q);
    cur_nibble = nibble_t'(val_ext >> (NIBBLE_W * digit_q));
  end

  assign upd_ready  = ~pend_full_q;
  assign select     = digit_q;
  assign nibble     = cur_nibble;
  assign blank      = ~en_ext[digit_q];
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed and random checks of the scanner against a cycle-count based reference model
module tb_seven_seg_scanner;
  localparam int DIV = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic [31:0] upd_value;
  logic [7:0]  upd_digit_en;
  logic        upd_ready, blank, frame_tick;
  logic [2:0]  select;
  logic [3:0]  nibble;
  logic        upd_valid4 = 1'b0;
  logic [15:0] upd_value4 = 16'h0;
  logic [3:0]  upd_digit_en4 = 4'h0;
  logic        upd_ready4, blank4, frame_tick4;
  logic [2:0]  select4;
  logic [3:0]  nibble4;
  int          n_chk = 0;
  int          n_fail = 0;
  int          k;
  logic        m_pend;
  logic [31:0] m_pv, m_av;
  logic [7:0]  m_pe, m_ae;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(8), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_value(upd_value),
    .upd_digit_en(upd_digit_en), .upd_ready(upd_ready), .select(select),
    .nibble(nibble), .blank(blank), .frame_tick(frame_tick)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(DIV)) dut4 (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid4), .upd_value(upd_value4),
    .upd_digit_en(upd_digit_en4), .upd_ready(upd_ready4), .select(select4),
    .nibble(nibble4), .blank(blank4), .frame_tick(frame_tick4)
  );

  // Reference model: k = clock edges since reset release; digit and boundaries follow from k arithmetically
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k <= 0;
      m_pend <= 1'b0;
      m_pv <= '0;
      m_pe <= '0;
      m_av <= '0;
      m_ae <= '0;
    end else begin
      if (k % (8 * DIV) == 8 * DIV - 1 && m_pend) begin
        m_av <= m_pv;
        m_ae <= m_pe;
        m_pend <= 1'b0;
      end else if (!m_pend && upd_valid) begin
        m_pv <= upd_value;
        m_pe <= upd_digit_en;
        m_pend <= 1'b1;
      end
      k <= k + 1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_all();
    int d;
    d = (k / DIV) % 8;
    chk("select", 32'(select), 32'(d));
    chk("nibble", 32'(nibble), (m_av >> (4 * d)) & 32'hF);
    chk("blank", 32'(blank), 32'(!m_ae[d]));
    chk("upd_ready", 32'(upd_ready), 32'(!m_pend));
    chk("frame_tick", 32'(frame_tick), 32'(k > 0 && k % (8 * DIV) == 0));
    chk("select4", 32'(select4), 32'((k / DIV) % 4));
    chk("frame_tick4", 32'(frame_tick4), 32'(k > 0 && k % (4 * DIV) == 0));
    chk("blank4", 32'(blank4), 32'd1);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  // advance until the model edge count hits the given phase within a frame
  task automatic wait_phase(input int ph, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (k % (8 * DIV) == ph) begin
        hit = 1'b1;
        break;
      end
      run(1);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  // hold an offer until the edge at which it is taken
  task automatic offer(input logic [31:0] v, input logic [7:0] en, input string tag);
    logic taken, was_ready;
    taken = 1'b0;
    upd_valid = 1'b1;
    upd_value = v;
    upd_digit_en = en;
    for (int i = 0; i < 200; i++) begin
      was_ready = !m_pend;
      run(1);
      if (was_ready) begin
        taken = 1'b1;
        break;
      end
    end
    upd_valid = 1'b0;
    chk(tag, 32'(taken), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    upd_valid = 1'b0;
    upd_value = '0;
    upd_digit_en = '0;
    #2;
    check_all();
    run(3);
    rst_n = 1'b1;
    run(70);
    wait_phase(3 * DIV, "reach_digit3");
    offer(32'h89ABCDEF, 8'hFF, "accept_89ABCDEF");
    run(80);
    offer(32'h11111111, 8'hFF, "accept_1s");
    offer(32'h22222222, 8'hFF, "accept_2s");
    run(80);
    offer(32'h12345678, 8'h0F, "accept_partial_en");
    run(80);
    wait_phase(8 * DIV - 1, "reach_boundary");
    offer(32'hCAFE0123, 8'hFF, "accept_at_boundary");
    run(80);
    wait_phase(2 * DIV, "reach_digit2");
    offer(32'h5A5A5A5A, 8'hFF, "accept_before_reset");
    wait_phase(5 * DIV + 1, "reach_digit5");
    #2 rst_n = 1'b0;
    #1 check_all();
    run(2);
    rst_n = 1'b1;
    run(70);
    repeat (1500) begin
      upd_valid = ($urandom % 4) == 0;
      upd_value = $urandom;
      upd_digit_en = 8'($urandom);
      run(1);
    end
    upd_valid = 1'b0;
    run(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Drives the digit-select / nibble interface of the seven-segment decoder.
- Holds a multi-digit hex value and time-multiplexes it one digit at a time at a programmable refresh rate.
- Accepts new display values through a valid/ready handshake and applies them only at frame boundaries, so no partial frame ever shows a mix of old and new values.
- Sits between the datapath (counters, registers under display) and the combinational segment decoder on the board top level.

Parameters:
- NUM_DIGITS, 8, digits scanned per frame; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles each digit stays selected; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- upd_valid  in  1  new display value offered
- upd_value  in  4*NUM_DIGITS  hex value; digit i = upd_value[4i+3:4i]
- upd_digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit blanked
- upd_ready  out  1  pending buffer empty; update can be accepted
- select  out  3  current digit index, to decoder select
- nibble  out  4  current digit value, to decoder input_bits
- blank  out  1  1 = current digit disabled; top level suppresses its anode
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is asynchronous on rst_n low. All of the following hold while rst_n is low and after release:
  - prescaler = 0, digit_idx = 0
  - active_value = 0, active_en = 0
  - pending_full = 0
  - frame_tick = 0
  - Resulting outputs: select = 0, nibble = 0, blank = 1, upd_ready = 1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where prescaler == REFRESH_DIV-1.
- Digit counter:
  - On tick, digit_idx <= (digit_idx == NUM_DIGITS-1) ? 0 : digit_idx+1.
  - digit_idx never reaches a value >= NUM_DIGITS.
- Outputs are pure functions of registered state, with no combinational path from any input:
  - select = digit_idx
  - nibble = active_value[4*digit_idx +: 4]
  - blank = ~active_en[digit_idx]
- Frame boundary = tick while digit_idx == NUM_DIGITS-1.
  - frame_tick is registered and is high for the single cycle after the boundary edge, i.e. while digit 0 of the new frame is showing.
- Handshake:
  - upd_ready = ~pending_full.
  - An accept (upd_valid && upd_ready) at a clock edge stores upd_value and upd_digit_en into the pending buffer and sets pending_full.
  - upd_valid while not ready is ignored; the producer holds it.
- Apply:
  - At a frame boundary edge with pending_full = 1: active <= pending and pending_full <= 0.
  - Digit 0 of the new frame therefore shows the new value with zero extra latency.
  - At a boundary with pending_full = 0, active is unchanged.
- Simultaneous events:
  - Boundary and accept in the same cycle cannot collide, because accept requires pending_full = 0. The accepted value goes to pending and is applied at the next boundary, not the current one.
  - After a transfer, upd_ready rises in the cycle following the boundary.
- Worst-case update latency is accept to display in at most one frame, i.e. NUM_DIGITS*REFRESH_DIV cycles.
- Reset mid-frame or mid-handshake:
  - Pending and active contents are discarded.
  - Scanning restarts at digit 0 with all digits blanked.
- Widths:
  - Prescaler width = $clog2(REFRESH_DIV).
  - digit_idx is 3 bits, and select stays 3 bits even when NUM_DIGITS < 8.

Decomposition:
- Package seven_seg_pkg holds:
  - MAX_DIGITS = 8
  - SEL_W = 3
  - NIBBLE_W = 4
  - typedef nibble_t = logic [NIBBLE_W-1:0]
- One sub-module, refresh_prescaler: parameter DIV, ports clk, rst_n, tick.
  - It is also reused by future scanned-display and debounce blocks.

Test Plan (REFRESH_DIV = 4, NUM_DIGITS = 8 unless stated):
- Reset release, no update → select steps 0,1,…,7,0 every 4 cycles; blank = 1 and nibble = 0 throughout; upd_ready = 1; frame_tick pulses every 32 cycles.
- Update value 0x89ABCDEF with en 0xFF, accepted mid-frame at digit 3 → upd_ready drops the next cycle. Digits 4..7 still show 0 with blank = 1. From the boundary, nibble sequence is F,E,D,C,B,A,9,8 with blank = 0, and upd_ready returns to 1 the cycle after the boundary.
- Back-to-back offers 0x11111111 then 0x22222222 within one frame → the second is stalled (upd_ready = 0) until the boundary. The first frame shows 1s and the following frame shows 2s; neither value is dropped or shown early.
- upd_digit_en = 0x0F with value 0x12345678 → digits 0..3 show 8,7,6,5 unblanked; digits 4..7 have blank = 1.
- Offer presented in the exact boundary cycle with pending empty → it is captured into pending, active is unchanged that frame, and the value appears at the following boundary.
- rst_n pulsed low asynchronously mid-digit at digit 5 with pending full → outputs go immediately to select = 0, blank = 1, upd_ready = 1. The pending value is never displayed, and scanning resumes from digit 0 after release.
- NUM_DIGITS = 4 build → select cycles 0..3 only and frame_tick pulses every 16 cycles.
